uart_program_loader: RTL

Sits between the UART receiver and the fetch stage / instruction memory. It turns the received byte stream into 32-bit instruction words and writes them sequentially into instruction memory. While a load is in progress it holds the CPU pipeline via cpu_hold. A load is requested by the flash input; the block handles length header, per-byte timeout, abort and error reporting.

---
 rtl/uart_program_loader_pkg.sv | 19 +
 rtl/uart_program_loader_word_assembler.sv | 53 +++++
 rtl/uart_program_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader.
//   loader_state_t : loader FSM states
//   HDR_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : bytes assembled into one instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_program_loader_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partial word and restart at byte 0
//   strobe     : byte_in is valid this cycle
//   byte_in    : incoming byte
//   byte_idx   : position the next byte will take (0 = bits [7:0])
//   word       : last completed word, held until the next one completes
//   word_valid : one-cycle pulse, the cycle after the last byte of a word
module word_assembler
  import loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          strobe,
  input  logic [7:0]                    byte_in,
  output logic [1:0]                    byte_idx,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_valid
);

  logic [8*(BYTES_PER_WORD-1)-1:0] partial;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (strobe) begin
        // Wraps back to 0 after the fourth byte.
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    partial[7:0]   <= byte_in;
          2'd1:    partial[15:8]  <= byte_in;
          2'd2:    partial[23:16] <= byte_in;
          default: begin
            word       <= {byte_in, partial};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program received over UART into instruction memory.
// Stream format: 16-bit little-endian word count N, then N words of 4
// little-endian bytes each. The CPU is held while a load is running and
// after a failed load (memory then holds a partial program).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flash               : load request level (rising edge starts, falling aborts)
//   uart_valid/uart_byte: received byte strobe and data
//   imem_we/addr/wdata  : one write per assembled word, sequential addresses
//   cpu_hold            : fetch must not advance
//   busy                : header or data phase in progress
//   load_done           : one-cycle pulse on success
//   load_error          : set on bad header, timeout or abort until next start
//   words_loaded        : words written by the current or most recent load
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_ADDR_W    = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flash,
  input  logic                   uart_valid,
  input  logic [7:0]             uart_byte,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   load_done,
  output logic                   load_error,
  output logic [IMEM_ADDR_W:0]   words_loaded
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAST_IDX   = 2'(BYTES_PER_WORD - 1);
  localparam int            HW         = 8 * HDR_BYTES;

  loader_state_t state, state_next;

  logic          flash_q;
  logic [7:0]    hdr_lo;
  logic [HW-1:0] hdr_n;
  logic [HW-1:0] n_rx;
  logic [TW-1:0] timer;
  logic [1:0]    byte_idx;

  logic flash_rise, flash_fall, start, in_load;
  logic accept, data_accept, last_write, timeout, hdr_ok;

  assign flash_rise = flash & ~flash_q;
  assign flash_fall = ~flash & flash_q;
  assign start      = flash_rise && (state == IDLE || state == ERROR);
  assign in_load    = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);

  // The write of the final word is in flight: bytes from here on belong to
  // nothing and are ignored.
  assign last_write  = (state == DATA) && imem_we &&
                       (32'(words_loaded) == 32'(hdr_n));
  // An abort in the same cycle drops the byte.
  assign accept      = uart_valid && in_load && !flash_fall && !last_write;
  assign data_accept = accept && (state == DATA);

  // Timer counts cycles since the last accepted byte; expiry at edge number
  // TIMEOUT_CYCLES after that byte's edge.
  assign timeout = ((state == HDR_HI) || (state == DATA)) && (timer == TIMER_LAST);

  assign n_rx   = {uart_byte, hdr_lo};
  assign hdr_ok = (n_rx != '0) && (32'(n_rx) <= (32'd1 << IMEM_ADDR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      flash_q <= 1'b0;
    end else begin
      state   <= state_next;
      flash_q <= flash;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_lo       <= '0;
      hdr_n        <= '0;
      timer        <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
    end else begin
      if (accept && state == HDR_LO) hdr_lo <= uart_byte;
      if (accept && state == HDR_HI) hdr_n  <= n_rx;

      if ((state == HDR_HI || state == DATA) && !accept) timer <= timer + 1'b1;
      else                                                timer <= '0;

      if (start) begin
        words_loaded <= '0;
      end else if (data_accept && byte_idx == LAST_IDX) begin
        // Address and count both appear in the cycle the write happens.
        imem_addr    <= words_loaded[IMEM_ADDR_W-1:0];
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != DATA),
    .strobe     (data_accept),
    .byte_in    (uart_byte),
    .byte_idx   (byte_idx),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      IDLE: begin
        if (flash_rise) state_next = HDR_LO;
      end
      HDR_LO: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (flash_fall)  state_next = IDLE;
        else if (accept) state_next = HDR_HI;
      end
      HDR_HI: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (flash_fall)   state_next = ERROR;
        else if (accept)  state_next = hdr_ok ? DATA : ERROR;
        else if (timeout) state_next = ERROR;
      end
      DATA: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (flash_fall)                state_next = ERROR;
        else if (last_write)           state_next = DONE;
        else if (timeout && !accept)   state_next = ERROR;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        load_error = 1'b1;
        cpu_hold   = 1'b1;
        if (flash_rise) state_next = HDR_LO;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
